// File: rtl/pwm_duty_meter_pkg.sv
// Shared definitions for the PWM duty meter: FSM states, percent scale, stuck-result helper.
package pwm_duty_meter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2,
        StDiv  = 2'd3
    } meter_state_e;

    localparam int unsigned PCT_SCALE = 100;
    localparam int unsigned PCT_W     = 7;

    // Duty reported for a constant line: fully high reads 100 %, fully low reads 0 %.
    function automatic logic [PCT_W-1:0] stuck_pct(input logic level);
        return level ? PCT_W'(PCT_SCALE) : '0;
    endfunction

endpackage

// File: rtl/pwm_duty_meter_div_seq.sv
// Restoring divider, one quotient bit per cycle. done is high in the cycle that performs
// the last iteration; quot is the combinational result of that iteration, so it is only
// meaningful while done is high.
module pwm_duty_meter_div_seq #(
    parameter int unsigned NUM_W = 23,
    parameter int unsigned DEN_W = 16
) (
    input  logic             hwclk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quot
);

    localparam int unsigned CNT_BITS = $clog2(NUM_W + 1);

    logic [DEN_W-1:0]    rem_q;
    logic [DEN_W-1:0]    den_q;
    logic [NUM_W-1:0]    q_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic                busy_q;

    logic [DEN_W:0]      rem_sh;
    logic [DEN_W+1:0]    diff;
    logic                q_bit;
    logic [DEN_W-1:0]    rem_nx;
    logic                unused_diff_bit;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh = {rem_q, q_q[NUM_W-1]};
        diff   = {1'b0, rem_sh} - {2'b00, den_q};
        q_bit  = ~diff[DEN_W+1];
        // Either branch is < den, so the top bit is always zero.
        rem_nx = q_bit ? diff[DEN_W-1:0] : rem_sh[DEN_W-1:0];
    end

    assign unused_diff_bit = diff[DEN_W];
    assign done = busy_q && (cnt_q == CNT_BITS'(NUM_W - 1));
    assign quot = {q_q[NUM_W-2:0], q_bit};
    assign busy = busy_q;

    // Load operands on start, then iterate NUM_W times.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            den_q  <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            den_q  <= den;
            q_q    <= num;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_nx;
            q_q   <= quot;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high-time and period of an asynchronous PWM line and publishes duty in percent,
// one result per measured period, or a stuck result when the line stops toggling.
module pwm_duty_meter
    import pwm_duty_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 30000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             hwclk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [PCT_W-1:0] duty_pct,
    output logic [CNT_W-1:0] period,
    output logic             stuck,
    output logic             valid
);

    localparam int unsigned NUM_W = CNT_W + PCT_W;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_q;
    logic                   rise_q;
    logic                   fall_q;

    meter_state_e           state_q;
    logic [CNT_W-1:0]       high_cnt_q;
    logic [CNT_W-1:0]       low_cnt_q;
    logic [CNT_W-1:0]       den_q;
    logic [CNT_W-1:0]       tmo_q;
    logic [PCT_W-1:0]       duty_q;
    logic [CNT_W-1:0]       period_q;
    logic                   stuck_q;
    logic                   valid_q;

    logic                   div_start;
    logic [NUM_W-1:0]       div_num;
    logic [CNT_W-1:0]       div_den;
    logic                   div_busy;
    logic                   div_done;
    logic [NUM_W-1:0]       div_quot;
    logic                   tmo_hit;
    logic                   unused_quot_hi;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Synchronizer plus edge detect; lvl_q is the level aligned with the rise/fall strobes.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            lvl_q  <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~lvl_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & lvl_q;
        end
    end

    // Divider is started straight from the closing rise so its latency starts at the strobe.
    always_comb begin
        div_start = rise_q && (state_q == StLow) && !div_busy;
        div_num   = NUM_W'(high_cnt_q) * NUM_W'(PCT_SCALE);
        div_den   = high_cnt_q + low_cnt_q;
        tmo_hit   = (tmo_q == CNT_W'(TIMEOUT - 1));
    end

    assign unused_quot_hi = ^div_quot[NUM_W-1:PCT_W];

    pwm_duty_meter_div_seq #(
        .NUM_W (NUM_W),
        .DEN_W (CNT_W)
    ) u_div (
        .hwclk (hwclk),
        .rst_n (rst_n),
        .start (div_start),
        .num   (div_num),
        .den   (div_den),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

    // Measurement FSM, timeout and registered result outputs.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            den_q      <= '0;
            tmo_q      <= '0;
            duty_q     <= '0;
            period_q   <= '0;
            stuck_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rise_q) begin
                        state_q    <= StHigh;
                        high_cnt_q <= CNT_W'(1);
                    end
                end
                StHigh: begin
                    if (fall_q) begin
                        state_q   <= StLow;
                        low_cnt_q <= CNT_W'(1);
                    end else begin
                        high_cnt_q <= sat_inc(high_cnt_q);
                    end
                end
                StLow: begin
                    if (div_start) begin
                        state_q <= StDiv;
                        den_q   <= div_den;
                    end else begin
                        low_cnt_q <= sat_inc(low_cnt_q);
                    end
                end
                StDiv: begin
                    if (div_done) begin
                        state_q  <= StIdle;
                        tmo_q    <= '0;
                        duty_q   <= div_quot[PCT_W-1:0];
                        period_q <= den_q;
                        stuck_q  <= 1'b0;
                        valid_q  <= 1'b1;
                    end
                end
            endcase
            // Timeout runs outside DIV; an edge in the same cycle takes precedence.
            if (state_q != StDiv) begin
                if (rise_q || fall_q) begin
                    tmo_q <= '0;
                end else if (tmo_hit) begin
                    tmo_q    <= '0;
                    state_q  <= StIdle;
                    duty_q   <= stuck_pct(lvl_q);
                    period_q <= '0;
                    stuck_q  <= 1'b1;
                    valid_q  <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
        end
    end

    assign duty_pct = duty_q;
    assign period   = period_q;
    assign stuck    = stuck_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: published results are captured by a monitor and
// compared against hand-computed values.
module tb_pwm_duty_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;
    localparam int SYNC    = 2;
    // pwm_in change -> strobe (SYNC+1) plus closing-rise strobe -> valid (CNT_W+8).
    localparam int LAT     = SYNC + 1 + CNT_W + 8;

    logic             hwclk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pwm_in = 1'b0;
    logic [6:0]       duty_pct;
    logic [CNT_W-1:0] period;
    logic             stuck;
    logic             valid;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        int duty;
        int period;
        int stuck;
        int cyc;
    } rec_t;

    rec_t recs[$];

    pwm_duty_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC)
    ) dut (
        .hwclk    (hwclk),
        .rst_n    (rst_n),
        .pwm_in   (pwm_in),
        .duty_pct (duty_pct),
        .period   (period),
        .stuck    (stuck),
        .valid    (valid)
    );

    always #5 hwclk = ~hwclk;

    always @(posedge hwclk) cyc <= cyc + 1;

    always @(negedge hwclk) begin
        if (valid) begin
            recs.push_back('{int'(duty_pct), int'(period), int'(stuck), cyc});
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge hwclk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input int n);
        pwm_in = v;
        step(n);
    endtask

    task automatic pwm_train(input int hi, input int lo, input int n);
        repeat (n) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);
        recs.delete();
    endtask

    task automatic wait_recs(input int n, input int budget);
        int k;
        k = 0;
        while (recs.size() < n && k < budget) begin
            step(1);
            k++;
        end
    endtask

    function automatic rec_t get_rec(input int i);
        rec_t r;
        r = '{-1, -1, -1, -1};
        if (i < recs.size()) r = recs[i];
        return r;
    endfunction

    initial begin
        rec_t r0;
        rec_t r1;
        int   t0;

        // Reset values
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        step(3);
        check_eq("rst_duty", int'(duty_pct), 0);
        check_eq("rst_period", int'(period), 0);
        check_eq("rst_stuck", int'(stuck), 0);
        check_eq("rst_valid", int'(valid), 0);

        // Line low from reset: stuck 0 % exactly TIMEOUT cycles after release
        rst_n = 1'b1;
        t0 = cyc;
        wait_recs(1, TIMEOUT + 50);
        r0 = get_rec(0);
        check_eq("low_count", recs.size(), 1);
        check_eq("low_duty", r0.duty, 0);
        check_eq("low_period", r0.period, 0);
        check_eq("low_stuck", r0.stuck, 1);
        check_eq("low_time", r0.cyc - t0, TIMEOUT);

        // 20/100 repeated: results on every other period
        do_reset();
        pwm_train(20, 80, 5);
        step(40);
        r0 = get_rec(0);
        r1 = get_rec(1);
        check_eq("p20_count", recs.size(), 2);
        check_eq("p20_duty0", r0.duty, 20);
        check_eq("p20_period0", r0.period, 100);
        check_eq("p20_stuck0", r0.stuck, 0);
        check_eq("p20_duty1", r1.duty, 20);
        check_eq("p20_period1", r1.period, 100);
        check_eq("p20_gap", r1.cyc - r0.cyc, 200);

        // 2/3 -> floor 66 %
        do_reset();
        pwm_train(2, 1, 3);
        step(40);
        r0 = get_rec(0);
        check_eq("p66_count", recs.size(), 1);
        check_eq("p66_duty", r0.duty, 66);
        check_eq("p66_period", r0.period, 3);

        // Single-cycle high in a 100-cycle period -> 1 %
        do_reset();
        pwm_train(1, 99, 2);
        step(40);
        r0 = get_rec(0);
        check_eq("p1_count", recs.size(), 1);
        check_eq("p1_duty", r0.duty, 1);
        check_eq("p1_period", r0.period, 100);

        // Extra edges during DIV are ignored; closing-rise -> valid latency
        do_reset();
        pwm_train(30, 70, 1);
        pwm_in = 1'b1;
        t0 = cyc;
        step(4);
        repeat (4) begin
            drive(1'b0, 2);
            drive(1'b1, 2);
        end
        drive(1'b0, 40);
        r0 = get_rec(0);
        check_eq("div_count", recs.size(), 1);
        check_eq("div_duty", r0.duty, 30);
        check_eq("div_period", r0.period, 100);
        check_eq("div_latency", r0.cyc - t0, LAT);

        // Stuck high repeats every TIMEOUT, then a 50 % signal measures normally
        do_reset();
        drive(1'b1, 1);
        wait_recs(2, 2 * TIMEOUT + 100);
        r0 = get_rec(0);
        r1 = get_rec(1);
        check_eq("hi_count", recs.size(), 2);
        check_eq("hi_duty0", r0.duty, 100);
        check_eq("hi_period0", r0.period, 0);
        check_eq("hi_stuck0", r0.stuck, 1);
        check_eq("hi_duty1", r1.duty, 100);
        check_eq("hi_stuck1", r1.stuck, 1);
        check_eq("hi_gap", r1.cyc - r0.cyc, TIMEOUT);
        recs.delete();
        drive(1'b0, 50);
        pwm_train(50, 50, 2);
        step(40);
        r0 = get_rec(0);
        check_eq("p50_count", recs.size(), 1);
        check_eq("p50_duty", r0.duty, 50);
        check_eq("p50_period", r0.period, 100);
        check_eq("p50_stuck", r0.stuck, 0);

        // Reset in the middle of DIV aborts the result
        do_reset();
        pwm_train(20, 80, 1);
        pwm_in = 1'b1;
        step(12);
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        step(3);
        check_eq("abort_valid", int'(valid), 0);
        check_eq("abort_duty", int'(duty_pct), 0);
        check_eq("abort_period", int'(period), 0);
        check_eq("abort_stuck", int'(stuck), 0);
        rst_n = 1'b1;
        step(40);
        check_eq("abort_none", recs.size(), 0);
        recs.delete();
        pwm_train(20, 80, 3);
        step(40);
        r0 = get_rec(0);
        check_eq("rec_count", recs.size(), 1);
        check_eq("rec_duty", r0.duty, 20);
        check_eq("rec_period", r0.period, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
